turn_input_ctrl: RTL

Parametrised turn and keypad-input controller for the N-cell mark-placement game. It accepts keypad strobes and validates them against the current post-elimination board. For each legal move it emits a one-cycle move record (cell, mark) to the board/elimination logic and alternates the player. It also runs a per-turn countdown that forfeits the turn on expiry and drives the two-digit time display.

---
 rtl/turn_input_ctrl_pkg.sv | 35 +++
 rtl/turn_input_ctrl_if.sv | 21 ++
 rtl/turn_input_ctrl_timer.sv | 63 ++++++
 rtl/turn_input_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/turn_input_ctrl_pkg.sv
// Shared definitions for the turn/keypad controller: mark encodings,
// controller states and the board_flat cell lookup helper.
package turn_input_ctrl_pkg;

    // Largest board the lookup helper can index; callers zero-extend
    // their board_flat to BOARD_W bits.
    localparam int MAX_CELLS = 32;
    localparam int BOARD_W   = 2 * MAX_CELLS;

    localparam logic [1:0] MARK_NONE = 2'b00;
    localparam logic [1:0] MARK_O    = 2'b01;
    localparam logic [1:0] MARK_X    = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Mark held in cell idx; cell i occupies bits [2i+1:2i].
    function automatic logic [1:0] cell_mark(
        input logic [BOARD_W-1:0] board,
        input logic [31:0]        idx
    );
        logic [1:0] m;
        m = MARK_NONE;
        for (int i = 0; i < MAX_CELLS; i++) begin
            if (idx == 32'(i)) begin
                m = board[2*i +: 2];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/turn_input_ctrl_if.sv
// Keypad strobe in / accepted move out bundle.
// master: keypad side (drives key_*), slave: controller (drives move_*).
interface turn_input_ctrl_if #(
    parameter int KEY_W = 4
);
    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic             move_valid;
    logic [KEY_W-1:0] move_loc;
    logic [1:0]       move_mark;

    modport master (
        output key_valid, key_code,
        input  move_valid, move_loc, move_mark
    );

    modport slave (
        input  key_valid, key_code,
        output move_valid, move_loc, move_mark
    );
endinterface

// File: rtl/turn_input_ctrl_timer.sv
// turn_timer: per-turn countdown with tick prescaler and digit split.
// Ports: clk, rst, reload, en in; expire (comb), time_hi/time_lo (reg) out.
module turn_timer #(
    parameter int TICK_DIV      = 1,
    parameter int TICKS_PER_SEC = 100,
    parameter int TURN_TICKS    = 800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reload,
    input  logic       en,
    output logic       expire,
    output logic [3:0] time_hi,
    output logic [3:0] time_lo
);

    // Counter wide enough for both the budget and the seconds divisor.
    localparam int CW = $clog2(10 * TICKS_PER_SEC);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LOAD  = CW'(TURN_TICKS);
    localparam logic [CW-1:0] SEC_DIV   = CW'(TICKS_PER_SEC);
    localparam logic [CW-1:0] TENTH_DIV = CW'(TICKS_PER_SEC / 10);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;
    logic [CW-1:0] cnt;
    logic          tick;

    function automatic logic [3:0] hi_of(input logic [CW-1:0] c);
        return 4'(c / SEC_DIV);
    endfunction

    function automatic logic [3:0] lo_of(input logic [CW-1:0] c);
        return 4'((c / TENTH_DIV) % CW'(10));
    endfunction

    assign tick   = en && (pre == PRE_LAST);
    // Expiry is the tick that finds the budget already used up.
    assign expire = tick && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre     <= '0;
            cnt     <= CNT_LOAD;
            time_hi <= hi_of(CNT_LOAD);
            time_lo <= lo_of(CNT_LOAD);
        end else begin
            time_hi <= hi_of(cnt);
            time_lo <= lo_of(cnt);
            if (reload) begin
                pre <= '0;
                cnt <= CNT_LOAD;
            end else if (en) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
                if (tick) begin
                    cnt <= (cnt == '0) ? CNT_LOAD : cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/turn_input_ctrl.sv
// turn_input_ctrl: validates keypad strobes against the board, emits
// move records, alternates players and forfeits turns on timer expiry.
// Ports: clk, rst, game_active, bus (slave: key_* in, move_* out),
// board_flat in; whos_turn, reject_pulse, timeout_pulse, time_hi/lo out.
module turn_input_ctrl
    import turn_input_ctrl_pkg::*;
#(
    parameter int CELLS         = 9,
    parameter int KEY_W         = 4,
    parameter int TICK_DIV      = 1,
    parameter int TICKS_PER_SEC = 100,
    parameter int TURN_TICKS    = 800,
    parameter bit START_X       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 game_active,
    turn_input_ctrl_if.slave     bus,
    input  logic [2*CELLS-1:0]   board_flat,
    output logic                 whos_turn,
    output logic                 reject_pulse,
    output logic                 timeout_pulse,
    output logic [3:0]           time_hi,
    output logic [3:0]           time_lo
);

    state_t             state;
    logic [KEY_W-1:0]   code;
    logic [31:0]        key_idx;
    logic [BOARD_W-1:0] board_ext;
    logic               in_run;
    logic               strobe;
    logic               legal;
    logic               accept;
    logic               refuse;
    logic               expire;
    logic               reload;

    assign code      = bus.key_code;
    assign key_idx   = 32'(code);
    assign board_ext = BOARD_W'(board_flat);

    assign in_run = game_active && (state == RUN);
    assign strobe = in_run && bus.key_valid;
    assign legal  = (key_idx < 32'(CELLS)) &&
                    (cell_mark(board_ext, key_idx) == MARK_NONE);
    assign accept = strobe && legal;
    assign refuse = strobe && !legal;

    // Timer only runs in RUN; an accepted move restarts the budget.
    assign reload = !in_run || accept;

    turn_timer #(
        .TICK_DIV      (TICK_DIV),
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .TURN_TICKS    (TURN_TICKS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .reload  (reload),
        .en      (in_run),
        .expire  (expire),
        .time_hi (time_hi),
        .time_lo (time_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            whos_turn      <= START_X;
            bus.move_valid <= 1'b0;
            bus.move_loc   <= '0;
            bus.move_mark  <= MARK_NONE;
            reject_pulse   <= 1'b0;
            timeout_pulse  <= 1'b0;
        end else begin
            bus.move_valid <= 1'b0;
            reject_pulse   <= 1'b0;
            timeout_pulse  <= 1'b0;
            if (!game_active) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE:   state <= RUN;
                    COMMIT: state <= RUN;
                    RUN: begin
                        // A legal move beats a same-cycle expiry; an
                        // expiry beats a refused strobe, since the
                        // timer has already reloaded for the next turn.
                        if (accept) begin
                            bus.move_valid <= 1'b1;
                            bus.move_loc   <= code;
                            bus.move_mark  <= whos_turn ? MARK_X : MARK_O;
                            whos_turn      <= ~whos_turn;
                            state          <= COMMIT;
                        end else if (expire) begin
                            timeout_pulse  <= 1'b1;
                            whos_turn      <= ~whos_turn;
                        end else if (refuse) begin
                            reject_pulse   <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
